// File: rtl/poly_line_raster.sv
// rtl/poly_line_raster.sv - vertex-fetching draw sequencer with a Bresenham line stepper
// Streams pixels for segment, strip and closed-loop vertex lists with valid/ready output.
module poly_line_raster #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] vert_count,
    output logic [AW-1:0] vert_addr,
    input  logic [XW-1:0] vert_x,
    input  logic [YW-1:0] vert_y,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_we,
    input  logic          pix_ready,
    output logic          busy,
    output logic          finish,
    output logic          err
);

    localparam int W = ((XW > YW) ? XW : YW) + 2;
    localparam logic signed [W-1:0] ONE = W'(1);
    localparam logic [AW:0] IDX_ONE = (AW+1)'(1);
    localparam logic [AW:0] IDX_TWO = (AW+1)'(2);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_A, S_WAIT_A, S_FETCH_B, S_WAIT_B,
        S_SETUP, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [XW-1:0] ax_q, ax_d, bx_q, bx_d, v0x_q, v0x_d;
    logic [YW-1:0] ay_q, ay_d, by_q, by_d, v0y_q, v0y_d;
    logic          closed_q, closed_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          sx_q, sx_d, sy_q, sy_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d, e_q, e_d, dx_q, dx_d, dy_q, dy_d;

    logic signed [W-1:0] ax_s, ay_s, bx_s, by_s, ddx, ddy, adx, ady, e_step;
    logic signed [W:0]   e2, dx_ext, dy_ext;
    logic                step_x, step_y, at_end;
    logic [AW-1:0]       fetch_addr;

    assign ax_s = signed'({{(W-XW){1'b0}}, ax_q});
    assign bx_s = signed'({{(W-XW){1'b0}}, bx_q});
    assign ay_s = signed'({{(W-YW){1'b0}}, ay_q});
    assign by_s = signed'({{(W-YW){1'b0}}, by_q});
    assign ddx  = bx_s - ax_s;
    assign ddy  = by_s - ay_s;
    assign adx  = (ddx < 0) ? -ddx : ddx;
    assign ady  = (ddy < 0) ? -ddy : ddy;

    // Doubled error is kept one bit wider so it cannot overflow at full-screen spans.
    assign e2     = {e_q, 1'b0};
    assign dx_ext = {dx_q[W-1], dx_q};
    assign dy_ext = {dy_q[W-1], dy_q};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);
    assign e_step = e_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    assign at_end = (x_q == bx_s) && (y_q == by_s);

    assign fetch_addr = base_q + idx_q[AW-1:0];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        bx_d     = bx_q;
        by_d     = by_q;
        v0x_d    = v0x_q;
        v0y_d    = v0y_q;
        closed_d = closed_q;
        we_d     = we_q;
        err_d    = err_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        x_d      = x_q;
        y_d      = y_q;
        e_d      = e_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    base_d   = base_addr;
                    count_d  = {1'b0, vert_count};
                    err_d    = 1'b0;
                    closed_d = 1'b0;
                    if (mode == 2'd3 || vert_count < AW'(2)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = base_addr;
                        idx_d   = IDX_ONE;
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_FETCH_A: state_d = S_WAIT_A;
            S_WAIT_A: begin
                ax_d = vert_x;
                ay_d = vert_y;
                if (idx_q == IDX_ONE) begin
                    v0x_d = vert_x;
                    v0y_d = vert_y;
                end
                addr_d  = fetch_addr;
                idx_d   = idx_q + IDX_ONE;
                state_d = S_FETCH_B;
            end
            S_FETCH_B: state_d = S_WAIT_B;
            S_WAIT_B: begin
                bx_d    = vert_x;
                by_d    = vert_y;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                x_d     = ax_s;
                y_d     = ay_s;
                dx_d    = adx;
                dy_d    = -ady;
                e_d     = adx - ady;
                sx_d    = (ddx < 0);
                sy_d    = (ddy < 0);
                we_d    = 1'b1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (we_q && pix_ready) begin
                    if (at_end) begin
                        we_d    = 1'b0;
                        state_d = S_NEXT;
                    end else begin
                        e_d = e_step;
                        if (step_x) x_d = sx_q ? x_q - ONE : x_q + ONE;
                        if (step_y) y_d = sy_q ? y_q - ONE : y_q + ONE;
                    end
                end
            end
            S_NEXT: begin
                if (mode_q == 2'd0) begin
                    if (count_q - idx_q >= IDX_TWO) begin
                        addr_d  = fetch_addr;
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_FETCH_A;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (idx_q < count_q) begin
                    ax_d    = bx_q;
                    ay_d    = by_q;
                    addr_d  = fetch_addr;
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_FETCH_B;
                end else if (mode_q == 2'd2 && !closed_q) begin
                    // Closing edge reuses the held first vertex instead of re-reading RAM.
                    ax_d     = bx_q;
                    ay_d     = by_q;
                    bx_d     = v0x_q;
                    by_d     = v0y_q;
                    closed_d = 1'b1;
                    state_d  = S_SETUP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            base_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            v0x_q    <= '0;
            v0y_q    <= '0;
            closed_q <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            e_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            v0x_q    <= v0x_d;
            v0y_q    <= v0y_d;
            closed_q <= closed_d;
            we_q     <= we_d;
            err_q    <= err_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            e_q      <= e_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    assign vert_addr = addr_q;
    assign pix_x     = x_q[XW-1:0];
    assign pix_y     = y_q[YW-1:0];
    assign pix_we    = we_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finish    = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_poly_line_raster.sv
// tb/tb_poly_line_raster.sv - scoreboard bench for poly_line_raster
// Expected pixels come from a queue filled by an integer line-drawing reference model.
module tb_poly_line_raster;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] vert_count;
    logic [AW-1:0] vert_addr;
    logic [XW-1:0] vert_x;
    logic [YW-1:0] vert_y;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_we;
    logic          pix_ready = 1'b1;
    logic          busy;
    logic          finish;
    logic          err;

    poly_line_raster #(.XW(XW), .YW(YW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .vert_count(vert_count), .vert_addr(vert_addr),
        .vert_x(vert_x), .vert_y(vert_y), .pix_x(pix_x), .pix_y(pix_y),
        .pix_we(pix_we), .pix_ready(pix_ready), .busy(busy), .finish(finish), .err(err)
    );

    always #5 clk = ~clk;

    logic [XW-1:0] mem_x [256];
    logic [YW-1:0] mem_y [256];
    always @(posedge clk) begin
        vert_x <= mem_x[vert_addr];
        vert_y <= mem_y[vert_addr];
    end

    int  n_checks = 0;
    int  n_pass = 0;
    int  exp_x[$];
    int  exp_y[$];
    bit  seen[256];
    int  fin_cnt = 0;
    bit  first_seen = 0;
    time first_t = 0;
    time t0 = 0;
    bit  prev_stall = 0;
    int  prev_x = 0;
    int  prev_y = 0;
    int  ready_mode = 0;
    int  pcnt = 0;
    logic [3:0] pat = 4'b1001;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) pix_ready = 1'b1;
        else if (ready_mode == 1) begin
            pix_ready = pat[pcnt % 4];
            pcnt++;
        end else pix_ready = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (busy) seen[vert_addr] = 1'b1;
            if (finish) fin_cnt++;
            if (prev_stall && pix_we)
                check(pix_x == prev_x && pix_y == prev_y, "stall_hold",
                      pix_x * 1000 + pix_y, prev_x * 1000 + prev_y);
            if (pix_we && pix_ready) begin
                if (!first_seen) begin
                    first_seen = 1;
                    first_t = $time;
                end
                if (exp_x.size() == 0) begin
                    check(0, "unexpected_pixel", pix_x * 1000 + pix_y, -1);
                end else begin
                    int ex, ey;
                    ex = exp_x.pop_front();
                    ey = exp_y.pop_front();
                    check(pix_x == ex && pix_y == ey, "pixel", pix_x * 1000 + pix_y, ex * 1000 + ey);
                end
            end
            prev_stall = pix_we && !pix_ready;
            prev_x = pix_x;
            prev_y = pix_y;
        end
    end

    task automatic push(input int x, input int y);
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    task automatic model_line(input int x0, input int y0, input int x1, input int y1);
        int x, y, dx, dy, sx, sy, e, e2;
        x = x0; y = y0;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        e = dx + dy;
        for (int guard = 0; guard < 4096; guard++) begin
            push(x, y);
            if (x == x1 && y == y1) break;
            e2 = 2 * e;
            if (e2 >= dy) begin e += dy; x += sx; end
            if (e2 <= dx) begin e += dx; y += sy; end
        end
    endtask

    function automatic int vx(input int base, input int i);
        return int'(mem_x[(base + i) & 255]);
    endfunction
    function automatic int vy(input int base, input int i);
        return int'(mem_y[(base + i) & 255]);
    endfunction

    task automatic model_draw(input int m, input int base, input int cnt);
        if (m == 0) begin
            for (int i = 0; i + 1 < cnt; i += 2)
                model_line(vx(base, i), vy(base, i), vx(base, i + 1), vy(base, i + 1));
        end else begin
            for (int i = 0; i + 1 < cnt; i++)
                model_line(vx(base, i), vy(base, i), vx(base, i + 1), vy(base, i + 1));
            if (m == 2)
                model_line(vx(base, cnt - 1), vy(base, cnt - 1), vx(base, 0), vy(base, 0));
        end
    endtask

    function automatic int seen_count();
        int n = 0;
        for (int i = 0; i < 256; i++) n += int'(seen[i]);
        return n;
    endfunction

    task automatic issue_start(input int m, input int base, input int cnt);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        first_seen = 0;
        @(posedge clk);
        #1;
        mode = 2'(m);
        base_addr = AW'(base);
        vert_count = AW'(cnt);
        start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1;
        start = 1'b0;
    endtask

    task automatic run_draw(input int m, input int base, input int cnt, input bit exp_err, input bit poke);
        logic [AW-1:0] addr_before;
        bit got;
        addr_before = vert_addr;
        issue_start(m, base, cnt);
        got = 0;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge clk);
            if (k == 0 && !exp_err) check(busy == 1'b1, "busy_after_start", busy, 1);
            if (poke && k == 3) begin
                start = 1'b1; mode = 2'd3; vert_count = '0;
            end
            if (poke && k == 4) start = 1'b0;
            if (finish) got = 1;
        end
        check(got, "finish_seen", got, 1);
        check(err == exp_err, "err_flag", err, exp_err);
        check(exp_x.size() == 0, "pixels_outstanding", exp_x.size(), 0);
        if (exp_err) check(vert_addr == addr_before, "no_ram_read", vert_addr, addr_before);
        exp_x.delete();
        exp_y.delete();
        @(negedge clk);
        check(finish == 1'b0, "finish_one_cycle", finish, 0);
        check(busy == 1'b0, "idle_after_done", busy, 0);
    endtask

    initial begin
        int fc;
        reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; vert_count = '0;
        for (int i = 0; i < 256; i++) begin mem_x[i] = '0; mem_y[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check(pix_we == 0 && busy == 0 && finish == 0 && err == 0, "reset_ctrl", {pix_we, busy, finish, err}, 0);
        check(pix_x == 0 && pix_y == 0, "reset_pix", pix_x * 1000 + pix_y, 0);
        check(vert_addr == 0, "reset_addr", vert_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Horizontal line, continuous ready, first pixel at edge 6
        mem_x[0] = 10'd0; mem_y[0] = 9'd0; mem_x[1] = 10'd5; mem_y[1] = 9'd0;
        for (int x = 0; x <= 5; x++) push(x, 0);
        run_draw(0, 0, 2, 0, 0);
        check(first_seen && first_t == t0 + 55, "first_pixel_latency", longint'(first_t - t0), 55);

        // Steep line in the documented Bresenham order
        mem_x[10] = 10'd2; mem_y[10] = 9'd1; mem_x[11] = 10'd4; mem_y[11] = 9'd7;
        push(2, 1); push(2, 2); push(3, 3); push(3, 4); push(3, 5); push(4, 6); push(4, 7);
        run_draw(0, 10, 2, 0, 0);

        // Closed triangle: 15 pixels, three RAM reads
        mem_x[20] = 10'd0; mem_y[20] = 9'd0; mem_x[21] = 10'd4; mem_y[21] = 9'd0;
        mem_x[22] = 10'd0; mem_y[22] = 9'd4;
        model_draw(2, 20, 3);
        check(exp_x.size() == 15, "loop_model_len", exp_x.size(), 15);
        run_draw(2, 20, 3, 0, 0);
        check(seen_count() == 3, "loop_ram_reads", seen_count(), 3);

        // Backpressure 1-0-0-1 with a start pulse while busy
        ready_mode = 1; pcnt = 0;
        for (int x = 0; x <= 5; x++) push(x, 0);
        run_draw(0, 0, 2, 0, 1);
        ready_mode = 0;

        // Error and degenerate cases
        run_draw(0, 40, 1, 1, 0);
        run_draw(3, 40, 4, 1, 0);
        run_draw(1, 40, 0, 1, 0);
        mem_x[30] = 10'd3; mem_y[30] = 9'd3; mem_x[31] = 10'd3; mem_y[31] = 9'd3;
        push(3, 3);
        run_draw(0, 30, 2, 0, 0);

        // Reset in the middle of the triangle
        model_draw(2, 20, 3);
        issue_start(2, 20, 3);
        repeat (9) @(negedge clk);
        check(busy == 1'b1, "busy_before_reset", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check(pix_we == 0 && busy == 0 && finish == 0 && err == 0, "async_reset_ctrl", {pix_we, busy, finish, err}, 0);
        check(pix_x == 0 && pix_y == 0 && vert_addr == 0, "async_reset_data",
              pix_x * 1000 + pix_y + vert_addr, 0);
        exp_x.delete();
        exp_y.delete();
        fc = fin_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check(fin_cnt == fc, "no_finish_after_reset", fin_cnt, fc);

        // Address wrap from 0xFF to 0x00
        mem_x[255] = 10'd6; mem_y[255] = 9'd2;
        model_draw(0, 255, 2);
        run_draw(0, 255, 2, 0, 0);
        check(seen[255] && seen[0] && seen_count() == 2, "wrap_addresses", seen_count(), 2);

        // Randomised draws with random backpressure
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = 10'($urandom_range(0, 40));
            mem_y[i] = 9'($urandom_range(0, 40));
        end
        ready_mode = 2;
        for (int t = 0; t < 12; t++) begin
            int m, b, c;
            m = $urandom_range(0, 2);
            b = $urandom_range(0, 255);
            c = $urandom_range(2, 7);
            model_draw(m, b, c);
            run_draw(m, b, c, 0, 0);
        end
        ready_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
